cache_way_data_array: RTL
=========================

// Module: cache_way_data_array
// PURPOSE
//   Set-associative cache data store: NUM_WAYS x NUM_SETS lines of WORDS_PER_LINE words.
//   CPU-side port: 1-cycle-latency registered read/write with byte/half/word access and sign/zero-extended loads.
//   Refill port: a line-fill sequencer writes a whole line from memory one beat per word.
//   Sits between the cache controller (tag/hit logic, way choice) and the core load/store unit.
// PARAMETERS
//   XLEN            32  data width; only 32 supported (4 byte lanes)
//   NUM_WAYS        2   associativity; WAY_SIZE = max(1,$clog2(NUM_WAYS))
//   NUM_SETS        4   sets per way; SET_SIZE = max(1,$clog2(NUM_SETS))
//   WORDS_PER_LINE  8   words per line; WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE)
//   BYTE_SELECT_SIZE is fixed at 2 (derived, not a parameter)
// PORTS
//   clk            in   1                 clock, all state on posedge
//   rst_n          in   1                 asynchronous active-low reset
//   req_valid      in   1                 CPU request present
//   req_ready      out  1                 array can accept a request this cycle
//   req_write      in   1                 1 = store, 0 = load
//   req_way        in   WAY_SIZE          target way
//   req_set        in   SET_SIZE          target set
//   req_word       in   WORD_SELECT_SIZE  word within line
//   req_byte       in   2                 byte within word
//   req_size       in   memory_operation_size_e  BYTE / HALF / WORD
//   req_unsigned   in   1                 load zero-extends if 1, sign-extends if 0
//   req_wdata      in   XLEN              store data, right-aligned
//   rsp_valid      out  1                 response for request accepted previous cycle
//   rsp_rdata      out  XLEN              load data (0 for stores and errors)
//   rsp_misaligned out  1                 request rejected as misaligned/illegal size
//   fill_start     in   1                 begin line refill (sampled in IDLE only)
//   fill_way       in   WAY_SIZE          refill way, captured at fill_start
//   fill_set       in   SET_SIZE          refill set, captured at fill_start
//   fill_valid     in   1                 refill beat present
//   fill_data      in   XLEN              refill word, beats in word order 0..WORDS_PER_LINE-1
//   fill_done      out  1                 1-cycle pulse: line fully written
// BEHAVIOUR
//   Reset: state=IDLE, beat counter=0, req_ready=0 while rst_n low, rsp_valid=0, rsp_rdata=0,
//     rsp_misaligned=0, fill_done=0. Array contents are not reset (X until written).
//   Reset asserted mid-fill aborts the fill; no fill_done; the partially written line is undefined.
//   FSM: IDLE -> FILL on fill_start; FILL -> DONE on the beat with counter==WORDS_PER_LINE-1;
//     DONE -> IDLE unconditionally (fill_done=1 in DONE only). fill_start outside IDLE is ignored.
//   req_ready = (state==IDLE) & ~fill_start; fill_start has priority over a CPU request in the same cycle.
//   FILL: each fill_valid cycle writes all 4 lanes of word[counter] in the captured way/set, counter++.
//     fill_valid low stalls the fill (no write, counter holds). Counter wraps to 0 in DONE.
//   Accept = req_valid & req_ready. Response exactly 1 cycle after accept; back-to-back accepts allowed;
//     rsp_valid=0 in any cycle not following an accept.
//   Alignment: HALF needs req_byte[0]==0; WORD needs req_byte==0; illegal size encodings are errors.
//     An error performs no write; response is rsp_misaligned=1, rsp_rdata=0.
//   Store: lane mask BYTE=0001<<byte, HALF=0011<<byte, WORD=1111; data replicated per lane
//     (byte x4, half x2); written at the accept edge; response rsp_rdata=0.
//   Load: word read at accept edge; byte/half extracted by req_byte, extended per req_unsigned,
//     registered into rsp_rdata. A load accepted the cycle after a store to the same word returns new data.
//   Ways/sets/words other than the addressed one are never modified.
// TESTING
//   1. Store WORD 0x8899AABB way1/set2/word3, then load BYTE signed byte1 -> rsp_rdata 0xFFFFFFAA, 1 cycle later.
//   2. Same word, load HALF unsigned byte2 -> 0x00008899; load HALF signed byte2 -> 0xFFFF8899.
//   3. Store BYTE 0x5A byte3 then WORD load -> 0x5A99AABB; way0/set2/word3 unchanged.
//   4. Load HALF byte1 or WORD byte2 -> rsp_misaligned=1, rdata 0; store with misaligned address leaves array unchanged.
//   5. fill_start way0/set1, 8 beats 0x100+i with fill_valid gaps -> req_ready=0 throughout, fill_done pulse
//      one cycle after beat 7, then WORD loads of words 0..7 return 0x100..0x107.
//   6. Assert rst_n low after 3 fill beats -> outputs at reset values, state IDLE; a new fill completes normally.

Source files
------------

// File: rtl/cache_way_data_array.sv
// ---------------------------------------------------------------------------
// cache_way_data_array
//   Set-associative cache data store: NUM_WAYS x NUM_SETS lines, each of
//   WORDS_PER_LINE XLEN-bit words. Two write sources share one write port:
//     - CPU port: 1-cycle-latency registered load/store with byte, half and
//       word access. Loads are sign- or zero-extended.
//     - Refill port: a line-fill sequencer writes a whole line, one beat per
//       word, into the way and set captured at fill_start.
//   The CPU port is held off (req_ready=0) while a fill is in progress, so
//   the two write sources never collide.
//
// Ports
//   clk, rst_n          clock (posedge) / asynchronous active-low reset
//   req_valid/ready     CPU request handshake
//   req_write           1 = store, 0 = load
//   req_way/set/word    line and word address
//   req_byte            byte offset within the word
//   req_size            memory_operation_size_e encoding (BYTE/HALF/WORD)
//   req_unsigned        load zero-extends when 1, sign-extends when 0
//   req_wdata           right-aligned store data
//   rsp_valid           response for the request accepted in the previous cycle
//   rsp_rdata           load data (0 for stores and errors)
//   rsp_misaligned      request rejected as misaligned or illegal size
//   fill_start          begin a line refill (honoured in IDLE only)
//   fill_way/set        refill target, captured at fill_start
//   fill_valid/data     refill beats in word order
//   fill_done           1-cycle pulse once the line is fully written
// ---------------------------------------------------------------------------
package cache_way_data_array_pkg;
    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10
    } memory_operation_size_e;
endpackage

module cache_way_data_array
    import cache_way_data_array_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_WAYS       = 2,
    parameter int NUM_SETS       = 4,
    parameter int WORDS_PER_LINE = 8,
    localparam int WAY_SIZE         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int SET_SIZE         = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [WAY_SIZE-1:0]         req_way,
    input  logic [SET_SIZE-1:0]         req_set,
    input  logic [WORD_SELECT_SIZE-1:0] req_word,
    input  logic [1:0]                  req_byte,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [XLEN-1:0]             req_wdata,
    output logic                        rsp_valid,
    output logic [XLEN-1:0]             rsp_rdata,
    output logic                        rsp_misaligned,
    input  logic                        fill_start,
    input  logic [WAY_SIZE-1:0]         fill_way,
    input  logic [SET_SIZE-1:0]         fill_set,
    input  logic                        fill_valid,
    input  logic [XLEN-1:0]             fill_data,
    output logic                        fill_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e                        state;
    logic [WORD_SELECT_SIZE-1:0]   beat_cnt;
    logic [WAY_SIZE-1:0]           fill_way_q;
    logic [SET_SIZE-1:0]           fill_set_q;

    // Data store; intentionally not reset.
    logic [XLEN-1:0] mem [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];

    // ---------------------------------------------------------------------
    // CPU request decode
    // ---------------------------------------------------------------------
    logic            accept;
    logic            req_err;
    logic [3:0]      lane_mask;
    logic [XLEN-1:0] store_data;

    assign req_ready = rst_n & (state == ST_IDLE) & ~fill_start;
    assign accept    = req_valid & req_ready;

    always_comb begin
        req_err    = 1'b0;
        lane_mask  = '0;
        store_data = req_wdata;
        case (req_size)
            MEM_SIZE_BYTE: begin
                lane_mask  = 4'b0001 << req_byte;
                store_data = {4{req_wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                req_err    = req_byte[0];
                lane_mask  = 4'b0011 << req_byte;
                store_data = {2{req_wdata[15:0]}};
            end
            MEM_SIZE_WORD: begin
                req_err    = (req_byte != 2'b00);
                lane_mask  = '1;
            end
            default: begin
                req_err    = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Shared write port: fill beats and CPU stores are mutually exclusive
    // because req_ready is low outside IDLE.
    // ---------------------------------------------------------------------
    logic                        cpu_wr;
    logic                        fill_wr;
    logic                        wr_en;
    logic [WAY_SIZE-1:0]         wr_way;
    logic [SET_SIZE-1:0]         wr_set;
    logic [WORD_SELECT_SIZE-1:0] wr_word;
    logic [3:0]                  wr_mask;
    logic [XLEN-1:0]             wr_data;

    assign cpu_wr  = accept & req_write & ~req_err;
    assign fill_wr = (state == ST_FILL) & fill_valid;
    assign wr_en   = cpu_wr | fill_wr;
    assign wr_way  = fill_wr ? fill_way_q : req_way;
    assign wr_set  = fill_wr ? fill_set_q : req_set;
    assign wr_word = fill_wr ? beat_cnt   : req_word;
    assign wr_mask = fill_wr ? 4'b1111    : lane_mask;
    assign wr_data = fill_wr ? fill_data  : store_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (wr_mask[lane]) begin
                    mem[wr_way][wr_set][wr_word][lane*8 +: 8] <= wr_data[lane*8 +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load path: read the addressed word, align the requested lane(s) to
    // bit 0, then extend.
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_shifted;
    logic [XLEN-1:0] load_data;

    assign rd_word    = mem[req_way][req_set][req_word];
    assign rd_shifted = rd_word >> {req_byte, 3'b000};

    always_comb begin
        load_data = rd_word;
        case (req_size)
            MEM_SIZE_BYTE: load_data = {{24{~req_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
            MEM_SIZE_HALF: load_data = {{16{~req_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
            default:       load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
        end else begin
            rsp_valid      <= accept;
            rsp_misaligned <= accept & req_err;
            rsp_rdata      <= (accept & ~req_write & ~req_err) ? load_data : '0;
        end
    end

    // ---------------------------------------------------------------------
    // Line-fill sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            fill_way_q <= '0;
            fill_set_q <= '0;
            fill_done  <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state      <= ST_FILL;
                        beat_cnt   <= '0;
                        fill_way_q <= fill_way;
                        fill_set_q <= fill_set;
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        if (beat_cnt == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1)) begin
                            state     <= ST_DONE;
                            fill_done <= 1'b1;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt  <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
